// File: rtl/mac_frame_scheduler.sv
// mac_frame_scheduler: runs bursts of generator frames through LOAD/PRESENT/RELEASE/GAP
// and hands each frame to the serializer over a valid/ready handshake.
module mac_frame_scheduler #(
    parameter int LEN_W        = 16,
    parameter int CNT_W        = 32,
    parameter int GAP_W        = 16,
    parameter int DONE_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_burst_start,
    input  logic             i_stop,
    input  logic [CNT_W-1:0] i_num_frames,
    input  logic [LEN_W-1:0] i_len_min,
    input  logic [LEN_W-1:0] i_len_max,
    input  logic [LEN_W-1:0] i_len_step,
    input  logic [7:0]       i_mode,
    input  logic [GAP_W-1:0] i_ifg_cycles,
    input  logic             i_gen_done,
    output logic             o_gen_start,
    output logic [LEN_W-1:0] o_gen_length,
    output logic [7:0]       o_gen_mode,
    output logic             o_prbs_rst_n,
    output logic             o_frame_valid,
    input  logic             i_frame_ready,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_frames_sent,
    output logic             o_burst_done,
    output logic             o_timeout_err
);
    localparam int TW = $clog2(DONE_TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(DONE_TIMEOUT - 1);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LOAD    = 3'd1;
    localparam logic [2:0] PRESENT = 3'd2;
    localparam logic [2:0] RELEASE = 3'd3;
    localparam logic [2:0] GAP     = 3'd4;

    logic [2:0]       state;
    logic [CNT_W-1:0] num;
    logic [LEN_W-1:0] len_min, len_max, len_step, len_next;
    logic [LEN_W:0]   len_sum;
    logic [GAP_W-1:0] ifg, gcnt;
    logic [TW-1:0]    tcnt;
    logic             stop_seen, finish;

    // One extra bit on the sum so a wrap past all-ones can never look like a legal length.
    always_comb begin
        len_sum  = {1'b0, o_gen_length} + {1'b0, len_step};
        len_next = (len_sum <= {1'b0, len_max}) ? len_sum[LEN_W-1:0] : len_min;
        finish   = (num != '0 && o_frames_sent == num) || stop_seen || i_stop;
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= IDLE;
            num           <= '0;
            len_min       <= '0;
            len_max       <= '0;
            len_step      <= '0;
            ifg           <= '0;
            gcnt          <= '0;
            tcnt          <= '0;
            stop_seen     <= 1'b0;
            o_gen_start   <= 1'b0;
            o_gen_length  <= '0;
            o_gen_mode    <= '0;
            o_prbs_rst_n  <= 1'b1;
            o_frame_valid <= 1'b0;
            o_busy        <= 1'b0;
            o_frames_sent <= '0;
            o_burst_done  <= 1'b0;
            o_timeout_err <= 1'b0;
        end else begin
            o_prbs_rst_n <= 1'b1;
            o_burst_done <= 1'b0;
            if (state != IDLE) stop_seen <= stop_seen | i_stop;
            case (state)
                IDLE: if (i_burst_start) begin
                    num           <= i_num_frames;
                    len_min       <= i_len_min;
                    len_max       <= i_len_max;
                    len_step      <= i_len_step;
                    ifg           <= i_ifg_cycles;
                    o_gen_mode    <= i_mode;
                    o_gen_length  <= i_len_min;
                    o_frames_sent <= '0;
                    o_timeout_err <= 1'b0;
                    o_prbs_rst_n  <= 1'b0;
                    stop_seen     <= i_stop;
                    o_busy        <= 1'b1;
                    o_gen_start   <= 1'b1;
                    tcnt          <= '0;
                    state         <= LOAD;
                end
                LOAD: begin
                    if (!i_gen_done) begin
                        o_frame_valid <= 1'b1;
                        state         <= PRESENT;
                    end else if (tcnt == T_LAST) begin
                        o_timeout_err <= 1'b1;
                        o_gen_start   <= 1'b0;
                        o_busy        <= 1'b0;
                        o_burst_done  <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                PRESENT: if (i_frame_ready) begin
                    o_frame_valid <= 1'b0;
                    o_gen_start   <= 1'b0;
                    if (o_frames_sent != '1) o_frames_sent <= o_frames_sent + CNT_W'(1);
                    tcnt          <= '0;
                    state         <= RELEASE;
                end
                RELEASE: begin
                    if (i_gen_done) begin
                        o_gen_length <= len_next;
                        gcnt         <= '0;
                        state        <= GAP;
                    end else if (tcnt == T_LAST) begin
                        o_timeout_err <= 1'b1;
                        o_busy        <= 1'b0;
                        o_burst_done  <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                GAP: begin
                    if (gcnt != ifg) begin
                        gcnt <= gcnt + GAP_W'(1);
                    end else if (finish) begin
                        o_busy       <= 1'b0;
                        o_burst_done <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        o_gen_start <= 1'b1;
                        tcnt        <= '0;
                        state       <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_frame_scheduler.sv
// tb_mac_frame_scheduler: scoreboard bench for the burst scheduler, with a
// generator model whose done follows !start after one cycle.
module tb_mac_frame_scheduler;
    localparam int LEN_W = 16;
    localparam int CNT_W = 32;
    localparam int GAP_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             i_burst_start = 1'b0, i_stop = 1'b0, i_frame_ready = 1'b1;
    logic [CNT_W-1:0] i_num_frames = '0;
    logic [LEN_W-1:0] i_len_min = '0, i_len_max = '0, i_len_step = '0;
    logic [7:0]       i_mode = '0;
    logic [GAP_W-1:0] i_ifg_cycles = '0;
    logic             gen_done, gen_q, stuck = 1'b0;
    logic             o_gen_start, o_prbs_rst_n, o_frame_valid, o_busy, o_burst_done, o_timeout_err;
    logic [LEN_W-1:0] o_gen_length;
    logic [7:0]       o_gen_mode;
    logic [CNT_W-1:0] o_frames_sent;

    int checks = 0, errors = 0;
    logic [LEN_W-1:0] exp_q[$], got_q[$];
    int n_done, n_prbs, n_starts, n_start_hi, min_gap, stall_cnt, stall_bad;
    logic [LEN_W-1:0] stall_len_v;

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) gen_q <= 1'b1;
        else gen_q <= !o_gen_start;
    assign gen_done = gen_q | stuck;

    mac_frame_scheduler dut (
        .clk(clk), .i_rst_n(rst_n), .i_burst_start(i_burst_start), .i_stop(i_stop),
        .i_num_frames(i_num_frames), .i_len_min(i_len_min), .i_len_max(i_len_max),
        .i_len_step(i_len_step), .i_mode(i_mode), .i_ifg_cycles(i_ifg_cycles),
        .i_gen_done(gen_done), .o_gen_start(o_gen_start), .o_gen_length(o_gen_length),
        .o_gen_mode(o_gen_mode), .o_prbs_rst_n(o_prbs_rst_n), .o_frame_valid(o_frame_valid),
        .i_frame_ready(i_frame_ready), .o_busy(o_busy), .o_frames_sent(o_frames_sent),
        .o_burst_done(o_burst_done), .o_timeout_err(o_timeout_err)
    );

    task automatic config_burst(input logic [CNT_W-1:0] n, input logic [LEN_W-1:0] lmin,
                                input logic [LEN_W-1:0] lmax, input logic [LEN_W-1:0] step,
                                input logic [GAP_W-1:0] gap);
        i_num_frames = n; i_len_min = lmin; i_len_max = lmax; i_len_step = step; i_ifg_cycles = gap;
    endtask

    // Pulses start, observes every cycle until 20 cycles past the burst_done pulse,
    // pushes each accepted length into got_q; optional stall and stop injection.
    task automatic run_burst(input int budget, input int stall_frame, input int stall_len, input int stop_frame);
        int idle = 0, post = 0;
        logic prev = 1'b0;
        got_q.delete();
        n_done = 0; n_prbs = 0; n_starts = 0; n_start_hi = 0; min_gap = 1 << 30;
        stall_cnt = 0; stall_bad = 0;
        i_burst_start = 1'b1;
        for (int c = 0; c < budget && post < 20; c++) begin
            @(negedge clk);
            i_burst_start = 1'b0;
            if (o_gen_start && !prev) begin
                n_starts++;
                if (n_starts > 1 && idle < min_gap) min_gap = idle;
                if (n_starts == stop_frame) i_stop = 1'b1;
            end
            idle = o_gen_start ? 0 : idle + 1;
            prev = o_gen_start;
            if (o_gen_start) n_start_hi++;
            if (!o_prbs_rst_n) n_prbs++;
            if (o_burst_done) n_done++;
            if (n_done > 0) post++;
            i_frame_ready = 1'b1;
            if (o_frame_valid && n_starts == stall_frame && stall_cnt < stall_len) begin
                if (stall_cnt == 0) stall_len_v = o_gen_length;
                else if (!o_gen_start || o_gen_length !== stall_len_v || o_timeout_err) stall_bad++;
                i_frame_ready = 1'b0;
                stall_cnt++;
            end
            if (o_frame_valid && i_frame_ready) got_q.push_back(o_gen_length);
        end
        checks++;
        if (post < 20) begin
            errors++;
            $display("FAIL run_burst: burst not finished in %0d cycles, done pulses %0d, required 1", budget, n_done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({o_gen_start, o_frame_valid, o_prbs_rst_n, o_busy, o_burst_done, o_timeout_err} !== 6'b001000) begin
            errors++;
            $display("FAIL reset_flags: got %b, required 001000",
                     {o_gen_start, o_frame_valid, o_prbs_rst_n, o_busy, o_burst_done, o_timeout_err});
        end
        checks++;
        if (o_frames_sent !== '0) begin errors++; $display("FAIL reset_frames_sent: got %0d, required 0", o_frames_sent); end
        checks++;
        if (o_gen_length !== '0) begin errors++; $display("FAIL reset_length: got %0d, required 0", o_gen_length); end
        checks++;
        if (o_gen_mode !== '0) begin errors++; $display("FAIL reset_mode: got %0d, required 0", o_gen_mode); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fixed();
        logic [LEN_W-1:0] e, g;
        config_burst(3, 46, 46, 0, 12);
        i_mode = 8'hA5;
        repeat (3) exp_q.push_back(16'd46);
        run_burst(400, 0, 0, 0);
        i_mode = 8'h00;
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL fixed_count: got %0d frames, required %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL fixed_length: got %0d, required %0d", g, e); end
        end
        exp_q.delete();
        checks++;
        if (o_frames_sent !== 32'd3) begin errors++; $display("FAIL fixed_frames_sent: got %0d, required 3", o_frames_sent); end
        checks++;
        if (n_starts != 3) begin errors++; $display("FAIL fixed_starts: got %0d, required 3", n_starts); end
        checks++;
        if (n_done != 1) begin errors++; $display("FAIL fixed_done_pulses: got %0d, required 1", n_done); end
        checks++;
        if (n_prbs != 1) begin errors++; $display("FAIL fixed_prbs_low: got %0d cycles, required 1", n_prbs); end
        checks++;
        if (min_gap < 12) begin errors++; $display("FAIL fixed_gap: got %0d idle cycles, required >= 12", min_gap); end
        checks++;
        if (o_gen_mode !== 8'hA5) begin errors++; $display("FAIL fixed_mode: got %h, required a5", o_gen_mode); end
        checks++;
        if (o_busy !== 1'b0) begin errors++; $display("FAIL fixed_busy: got %b, required 0", o_busy); end
    endtask

    task automatic test_sweep();
        logic [LEN_W-1:0] e, g;
        config_burst(5, 46, 60, 7, 0);
        exp_q.push_back(16'd46); exp_q.push_back(16'd53); exp_q.push_back(16'd60);
        exp_q.push_back(16'd46); exp_q.push_back(16'd53);
        run_burst(400, 0, 0, 0);
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL sweep_count: got %0d frames, required %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL sweep_length: got %0d, required %0d", g, e); end
        end
        exp_q.delete();
        checks++;
        if (o_frames_sent !== 32'd5) begin errors++; $display("FAIL sweep_frames_sent: got %0d, required 5", o_frames_sent); end
    endtask

    task automatic test_backpressure();
        logic [LEN_W-1:0] e, g;
        config_burst(2, 50, 50, 0, 2);
        repeat (2) exp_q.push_back(16'd50);
        run_burst(400, 1, 20, 0);
        checks++;
        if (stall_cnt != 20) begin errors++; $display("FAIL bp_stall_cycles: got %0d, required 20", stall_cnt); end
        checks++;
        if (stall_bad != 0) begin errors++; $display("FAIL bp_hold: got %0d bad cycles, required 0", stall_bad); end
        checks++;
        if (o_timeout_err !== 1'b0) begin errors++; $display("FAIL bp_timeout: got %b, required 0", o_timeout_err); end
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_count: got %0d frames, required %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL bp_length: got %0d, required %0d", g, e); end
        end
        exp_q.delete();
        checks++;
        if (o_frames_sent !== 32'd2) begin errors++; $display("FAIL bp_frames_sent: got %0d, required 2", o_frames_sent); end
    endtask

    task automatic test_continuous_stop();
        logic [LEN_W-1:0] e, g;
        config_burst(0, 64, 64, 0, 3);
        repeat (4) exp_q.push_back(16'd64);
        run_burst(600, 0, 0, 4);
        i_stop = 1'b0;
        checks++;
        if (n_starts != 4) begin errors++; $display("FAIL stop_starts: got %0d, required 4", n_starts); end
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL stop_count: got %0d frames, required %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL stop_length: got %0d, required %0d", g, e); end
        end
        exp_q.delete();
        checks++;
        if (o_frames_sent !== 32'd4) begin errors++; $display("FAIL stop_frames_sent: got %0d, required 4", o_frames_sent); end
        checks++;
        if (n_done != 1) begin errors++; $display("FAIL stop_done_pulses: got %0d, required 1", n_done); end
    endtask

    task automatic test_timeout();
        logic [LEN_W-1:0] g;
        stuck = 1'b1;
        config_burst(1, 46, 46, 0, 0);
        run_burst(200, 0, 0, 0);
        checks++;
        if (o_timeout_err !== 1'b1) begin errors++; $display("FAIL to_err_set: got %b, required 1", o_timeout_err); end
        checks++;
        if (n_start_hi != 16) begin errors++; $display("FAIL to_load_cycles: got %0d, required 16", n_start_hi); end
        checks++;
        if ({o_gen_start, o_busy, o_frame_valid} !== 3'b000) begin
            errors++; $display("FAIL to_idle: got %b, required 000", {o_gen_start, o_busy, o_frame_valid});
        end
        checks++;
        if (got_q.size() != 0 || n_done != 1) begin
            errors++; $display("FAIL to_frames: got %0d frames %0d done pulses, required 0 and 1", got_q.size(), n_done);
        end
        stuck = 1'b0;
        @(negedge clk);
        exp_q.push_back(16'd46);
        run_burst(200, 0, 0, 0);
        checks++;
        if (o_timeout_err !== 1'b0) begin errors++; $display("FAIL to_err_clear: got %b, required 0", o_timeout_err); end
        checks++;
        if (got_q.size() != 1) begin errors++; $display("FAIL to_recover_count: got %0d frames, required 1", got_q.size()); end
        else begin
            g = got_q.pop_front();
            checks++;
            if (g !== exp_q[0]) begin errors++; $display("FAIL to_recover_length: got %0d, required %0d", g, exp_q[0]); end
        end
        exp_q.delete();
    endtask

    task automatic test_async_reset();
        logic [LEN_W-1:0] e, g;
        int c;
        config_burst(2, 50, 50, 0, 0);
        i_frame_ready = 1'b0;
        i_burst_start = 1'b1;
        @(negedge clk);
        i_burst_start = 1'b0;
        for (c = 0; c < 40 && !o_frame_valid; c++) @(negedge clk);
        checks++;
        if (o_frame_valid !== 1'b1) begin errors++; $display("FAIL ar_present: valid got %b, required 1", o_frame_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({o_gen_start, o_frame_valid, o_busy, o_prbs_rst_n} !== 4'b0001) begin
            errors++; $display("FAIL ar_async: got %b, required 0001", {o_gen_start, o_frame_valid, o_busy, o_prbs_rst_n});
        end
        @(negedge clk);
        rst_n = 1'b1;
        i_frame_ready = 1'b1;
        @(negedge clk);
        repeat (2) exp_q.push_back(16'd50);
        run_burst(200, 0, 0, 0);
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ar_count: got %0d frames, required %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL ar_length: got %0d, required %0d", g, e); end
        end
        exp_q.delete();
        checks++;
        if (o_frames_sent !== 32'd2) begin errors++; $display("FAIL ar_frames_sent: got %0d, required 2", o_frames_sent); end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_sweep();
        test_backpressure();
        test_continuous_stop();
        test_timeout();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
